ifq_fetch_buffer: RTL and testbench
===================================

Name: ifq_fetch_buffer

Overview:
- Consumer end of the fetch-stage output interface: accepts {PC4, Instr} pairs from the fetch stage and presents them to decode in order.
- Sits between the fetch stage and the ID stage as a small in-order FIFO, so a decode stall does not immediately stall PC update.
- full drives the fetch stall; flush discards wrong-path instructions on a taken branch or jump redirect.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
ADDR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
push  input  1  fetch stage presents a valid pair this cycle
PC4_in  input  32  PC+4 of the fetched instruction
Instr_in  input  32  fetched instruction word
pop  input  1  decode consumes the head entry this cycle
flush  input  1  redirect; discard all entries and any push this cycle
Instr_D  output  32  head instruction; 32'h0 (nop) when empty
PC4_D  output  32  head PC+4; 32'h0 when empty
valid_D  output  1  head entry valid (equals ~empty)
full  output  1  count == DEPTH; feeds StallF
empty  output  1  count == 0
count  output  ADDR_W+1  occupancy, 0..DEPTH
err_ovf  output  1  sticky: push attempted while full without pop

Behaviour:
- Reset (asynchronous, active-high): rd_ptr=0, wr_ptr=0, count=0, err_ovf=0, so empty=1, full=0, valid_D=0, Instr_D=0, PC4_D=0. Storage contents need not be cleared. Reset mid-operation abandons all entries; the first post-reset push lands at index 0.
- First-word fall-through: Instr_D/PC4_D combinationally show mem[rd_ptr] when count!=0, else forced to 0.
- do_pop = pop & ~empty. A pop while empty is ignored with no pointer change.
- do_push = push & (~full | do_pop). A push while full with a simultaneous pop is accepted.
- Push while full without pop: data dropped, pointers unchanged, err_ovf set to 1 and held until reset.
- Per edge, when flush=0:
  - On do_push: mem[wr_ptr] <= {PC4_in, Instr_in} and wr_ptr+1.
  - On do_pop: rd_ptr+1.
  - count <= count + do_push - do_pop. Push+pop together leaves count unchanged.
- Pointers wrap modulo DEPTH (natural ADDR_W-bit overflow).
- Empty with push+pop in the same cycle: the pop is ignored and the push is accepted, so count becomes 1. There is no bypass, so latency is 1 cycle from push to valid_D.
- flush=1 (highest priority after reset): rd_ptr <= 0, wr_ptr <= 0, count <= 0 on that edge. Push and pop in the same cycle are discarded. err_ovf is unaffected.
- Data written is never reordered; the head is always the oldest accepted entry.
- Outputs full/empty/valid_D/count derive from count only, so no extra registers are needed.

Test Plan:
- Reset, then idle -> count=0, empty=1, full=0, valid_D=0, Instr_D=0, PC4_D=0, err_ovf=0.
- Push 4 pairs (PC4=0x3004,0x3008,0x300C,0x3010; Instr=0x24010001..0x24010004), pop=0 -> full=1, count=4, Instr_D=0x24010001; a 5th push (0x24010005) sets err_ovf=1 and count stays 4. Pop 4 times -> Instr_D 0x24010001..04 in order, then empty=1, Instr_D=0.
- Full (4 entries), push 0x24010005 with pop=1 -> count stays 4, err_ovf stays 0; four more pops yield 0x24010002..05, confirming pointer wrap.
- Empty, push 0x8C220000 with pop=1 -> count=1, valid_D=1 next cycle, Instr_D=0x8C220000.
- Load 3 entries, assert flush with push=1 (0x10000003) and pop=1 -> count=0, empty=1. Next push 0x00000000/PC4 0x4004 appears at the head alone.
- Load 2 entries, assert reset between clock edges -> count=0 and valid_D=0 immediately without waiting for a clock edge; err_ovf cleared.

Source files
------------

// File: rtl/ifq_fetch_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side driving push/pop/flush, slave = the buffer.
interface ifq_fetch_if #(
    parameter int ADDR_W = 2
);
    logic              push;
    logic [31:0]       PC4_in;
    logic [31:0]       Instr_in;
    logic              pop;
    logic              flush;
    logic [31:0]       Instr_D;
    logic [31:0]       PC4_D;
    logic              valid_D;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              err_ovf;

    modport master (
        output push, PC4_in, Instr_in, pop, flush,
        input  Instr_D, PC4_D, valid_D, full, empty, count, err_ovf
    );

    modport slave (
        input  push, PC4_in, Instr_in, pop, flush,
        output Instr_D, PC4_D, valid_D, full, empty, count, err_ovf
    );
endinterface

// File: rtl/ifq_fetch_buffer.sv
// In-order {PC4, Instr} FIFO between fetch and decode with first-word
// fall-through head, redirect flush and a sticky overflow flag.
module ifq_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    ifq_fetch_if.slave  bus
);
    logic [63:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_ovf_q, err_ovf_d;
    logic              is_empty, is_full;
    logic              do_push, do_pop;
    logic              wr_en;
    logic [63:0]       head;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign do_pop   = bus.pop & ~is_empty;
    // A pop frees the slot this same edge, so a push into a full queue is fine then.
    assign do_push  = bus.push & (~is_full | do_pop);
    assign wr_en    = do_push & ~bus.flush;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
            if (bus.push && is_full && !do_pop) err_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Storage is never reset; the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {bus.PC4_in, bus.Instr_in};
    end

    assign head        = mem_q[rd_ptr_q];
    assign bus.Instr_D = is_empty ? 32'h0 : head[31:0];
    assign bus.PC4_D   = is_empty ? 32'h0 : head[63:32];
    assign bus.valid_D = ~is_empty;
    assign bus.full    = is_full;
    assign bus.empty   = is_empty;
    assign bus.count   = count_q;
    assign bus.err_ovf = err_ovf_q;
endmodule

// File: tb/tb_ifq_fetch_buffer.sv
// Scoreboard bench for ifq_fetch_buffer: directed scenarios then random
// push/pop/flush traffic checked against a queue-based reference model.
module tb_ifq_fetch_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [63:0] sb_q [$];
    logic        exp_err;

    ifq_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    ifq_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT against the model, then advance the model
    // with the inputs the DUT will see on the coming rising edge.
    always begin
        logic accept, popped;
        @(negedge clk);
        if (reset) begin
            sb_q.delete();
            exp_err = 1'b0;
        end
        chk("count",   64'(bus.count),   64'(sb_q.size()));
        chk("empty",   64'(bus.empty),   64'(sb_q.size() == 0));
        chk("full",    64'(bus.full),    64'(sb_q.size() == DEPTH));
        chk("valid_D", 64'(bus.valid_D), 64'(sb_q.size() != 0));
        chk("err_ovf", 64'(bus.err_ovf), 64'(exp_err));
        chk("Instr_D", 64'(bus.Instr_D), (sb_q.size() != 0) ? 64'(sb_q[0][31:0])  : 64'h0);
        chk("PC4_D",   64'(bus.PC4_D),   (sb_q.size() != 0) ? 64'(sb_q[0][63:32]) : 64'h0);
        if (!reset) begin
            if (bus.flush) begin
                $display("flush discard=%0d", sb_q.size());
                sb_q.delete();
            end else begin
                popped = bus.pop && (sb_q.size() != 0);
                accept = bus.push && (sb_q.size() < DEPTH || popped);
                if (popped) begin
                    $display("pop  pc4=%h instr=%h", sb_q[0][63:32], sb_q[0][31:0]);
                    void'(sb_q.pop_front());
                end
                if (bus.push && !accept) begin
                    exp_err = 1'b1;
                    $display("push dropped (queue full) instr=%h", bus.Instr_in);
                end
                if (accept) begin
                    sb_q.push_back({bus.PC4_in, bus.Instr_in});
                    $display("push pc4=%h instr=%h", bus.PC4_in, bus.Instr_in);
                end
            end
        end
    end

    task automatic step(input logic p, input logic [31:0] pc4, input logic [31:0] ins,
                        input logic o, input logic f);
        @(posedge clk);
        #1;
        bus.push     = p;
        bus.PC4_in   = pc4;
        bus.Instr_in = ins;
        bus.pop      = o;
        bus.flush    = f;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reset raised between edges; state must clear before any further clock edge.
    task automatic async_reset();
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count",   64'(bus.count),   64'h0);
        chk("rst_valid_D", 64'(bus.valid_D), 64'h0);
        chk("rst_err_ovf", 64'(bus.err_ovf), 64'h0);
        chk("rst_Instr_D", 64'(bus.Instr_D), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load(input int n, input logic [31:0] pc_base, input logic [31:0] ins_base);
        for (int i = 0; i < n; i++)
            step(1'b1, pc_base + 32'(4 * i), ins_base + 32'(i), 1'b0, 1'b0);
    endtask

    task automatic pops(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_err = 1'b0;
        reset = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
        bus.PC4_in = 32'h0; bus.Instr_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(); idle();

        // Fill, overflow, drain in order.
        load(4, 32'h3004, 32'h24010001);
        step(1'b1, 32'h3014, 32'h24010005, 1'b0, 1'b0);
        pops(4);
        idle(); idle();

        // Full with simultaneous push+pop, then drain across the pointer wrap.
        async_reset();
        load(4, 32'h3004, 32'h24010001);
        step(1'b1, 32'h3014, 32'h24010005, 1'b1, 1'b0);
        pops(4);
        idle();

        // Empty with push+pop together: push accepted, pop ignored.
        step(1'b1, 32'h5004, 32'h8C220000, 1'b1, 1'b0);
        idle();
        pops(1);
        idle();

        // Flush discards queue contents plus that cycle's push and pop.
        load(3, 32'h6004, 32'h20000001);
        step(1'b1, 32'h7004, 32'h10000003, 1'b1, 1'b1);
        step(1'b1, 32'h4004, 32'h00000000, 1'b0, 1'b0);
        idle();
        pops(1);
        idle();

        // Overflow to set err_ovf, leave 2 entries, then reset mid-cycle.
        load(4, 32'h8004, 32'h30000001);
        step(1'b1, 32'h8014, 32'h30000005, 1'b0, 1'b0);
        pops(2);
        idle();
        async_reset();
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), $urandom, $urandom,
                 ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 3));
        end
        idle();
        pops(DEPTH);
        idle();

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
